core_ls_biu: RTL and testbench

CORE_LS_BIU -- requirements
Module: core_ls_biu

---
 rtl/core_ls_biu_pkg.sv | 29 ++
 rtl/core_ls_biu_tmo.sv | 50 +++++
 rtl/core_ls_biu.sv | 167 ++++++++++++++++
 tb/tb_core_ls_biu.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ls_biu_pkg.sv
// -----------------------------------------------------------------------------
// core_ls_biu_pkg
// Shared definitions for the load/store bus interface unit: core data width,
// LSU write-mask width, default response timeout, FSM state encodings and a
// word-alignment helper.
// -----------------------------------------------------------------------------
package core_ls_biu_pkg;

  localparam int CORE_XLEN            = 32;
  localparam int CORE_LSU_WMASK_WIDTH = CORE_XLEN / 8;
  localparam int CORE_BIU_TIMEOUT     = 256;
  // Wide enough for the largest legal TIMEOUT (65535).
  localparam int CORE_BIU_TMO_W       = 16;

  typedef enum logic [1:0] {
    BIU_IDLE     = 2'd0,
    BIU_REQ      = 2'd1,
    BIU_WAIT_RSP = 2'd2,
    BIU_RSP      = 2'd3
  } biu_state_e;

  // The memory side only sees word addresses; byte lanes are the LSU's job.
  function automatic logic [CORE_XLEN-1:0] biu_word_align(
    input logic [CORE_XLEN-1:0] addr
  );
    return {addr[CORE_XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/core_ls_biu_tmo.sv
// -----------------------------------------------------------------------------
// core_ls_biu_tmo
// Response timeout counter for the BIU.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clr_i      - clear the count (entry into WAIT_RSP)
//   inc_i      - count one WAIT_RSP cycle without a memory response
//   expired_o  - count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module core_ls_biu_tmo
  import core_ls_biu_pkg::*;
#(
  parameter int TIMEOUT = CORE_BIU_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [CORE_BIU_TMO_W-1:0] TMO_LAST = CORE_BIU_TMO_W'(TIMEOUT - 1);

  logic [CORE_BIU_TMO_W-1:0] cnt_q;
  logic [CORE_BIU_TMO_W-1:0] cnt_d;

  // Next count: clear wins, and the count saturates at the expiry value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != TMO_LAST)) begin
      cnt_d = cnt_q + CORE_BIU_TMO_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == TMO_LAST);

endmodule

// File: rtl/core_ls_biu.sv
// -----------------------------------------------------------------------------
// core_ls_biu
// Load/store bus interface unit: takes one LSU request at a time, forwards it
// to memory as a word-aligned access, waits for the memory response (or a
// timeout) and hands the result back to the LSU.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   req_valid/req_ready              - LSU request handshake
//   req_addr/req_wen/req_wdata/req_wmask - LSU request payload
//   rsp_valid/rsp_ready              - LSU response handshake
//   rsp_rdata/rsp_err                - LSU response payload
//   mem_req_valid/mem_req_ready      - memory request handshake
//   mem_addr/mem_wen/mem_wdata/mem_wmask - memory request payload
//   mem_rsp_valid/mem_rsp_rdata/mem_rsp_err - memory response (no backpressure)
// -----------------------------------------------------------------------------
module core_ls_biu
  import core_ls_biu_pkg::*;
#(
  parameter int TIMEOUT = CORE_BIU_TIMEOUT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [CORE_XLEN-1:0]            req_addr,
  input  logic                            req_wen,
  input  logic [CORE_XLEN-1:0]            req_wdata,
  input  logic [CORE_LSU_WMASK_WIDTH-1:0] req_wmask,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [CORE_XLEN-1:0]            rsp_rdata,
  output logic                            rsp_err,
  output logic                            mem_req_valid,
  input  logic                            mem_req_ready,
  output logic [CORE_XLEN-1:0]            mem_addr,
  output logic                            mem_wen,
  output logic [CORE_XLEN-1:0]            mem_wdata,
  output logic [CORE_LSU_WMASK_WIDTH-1:0] mem_wmask,
  input  logic                            mem_rsp_valid,
  input  logic [CORE_XLEN-1:0]            mem_rsp_rdata,
  input  logic                            mem_rsp_err
);

  biu_state_e                      state_q, state_d;
  logic [CORE_XLEN-1:0]            addr_q, addr_d;
  logic                            wen_q, wen_d;
  logic [CORE_XLEN-1:0]            wdata_q, wdata_d;
  logic [CORE_LSU_WMASK_WIDTH-1:0] wmask_q, wmask_d;
  logic [CORE_XLEN-1:0]            rdata_q, rdata_d;
  logic                            err_q, err_d;

  logic tmo_clr_s;
  logic tmo_inc_s;
  logic tmo_expired_s;

  core_ls_biu_tmo #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmo_clr_s),
    .inc_i     (tmo_inc_s),
    .expired_o (tmo_expired_s)
  );

  // Next-state, payload capture and handshake outputs.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    tmo_clr_s     = 1'b0;
    tmo_inc_s     = 1'b0;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    rsp_valid     = 1'b0;

    case (state_q)
      BIU_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = biu_word_align(req_addr);
          wen_d   = req_wen;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          state_d = BIU_REQ;
        end else begin
          state_d = BIU_IDLE;
        end
      end

      BIU_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          tmo_clr_s = 1'b1;
          state_d   = BIU_WAIT_RSP;
        end else begin
          state_d = BIU_REQ;
        end
      end

      BIU_WAIT_RSP: begin
        // A response arriving on the expiry cycle still counts as a response.
        if (mem_rsp_valid) begin
          rdata_d = wen_q ? '0 : mem_rsp_rdata;
          err_d   = mem_rsp_err;
          state_d = BIU_RSP;
        end else if (tmo_expired_s) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = BIU_RSP;
        end else begin
          tmo_inc_s = 1'b1;
          state_d   = BIU_WAIT_RSP;
        end
      end

      BIU_RSP: begin
        rsp_valid = 1'b1;
        // Returning to IDLE costs a cycle, so no new request can be taken
        // on the response handshake edge.
        if (rsp_ready) begin
          state_d = BIU_IDLE;
        end else begin
          state_d = BIU_RSP;
        end
      end

      default: begin
        state_d = BIU_IDLE;
      end
    endcase
  end

  // State and payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BIU_IDLE;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Payloads read as zero whenever their valid is low.
  assign mem_addr  = mem_req_valid ? addr_q  : '0;
  assign mem_wen   = mem_req_valid ? wen_q   : 1'b0;
  assign mem_wdata = mem_req_valid ? wdata_q : '0;
  assign mem_wmask = mem_req_valid ? wmask_q : '0;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid ? err_q   : 1'b0;

endmodule

// File: tb/tb_core_ls_biu.sv
// -----------------------------------------------------------------------------
// tb_core_ls_biu
// Directed bench for core_ls_biu with TIMEOUT=8. Expected memory requests and
// LSU responses are queued by the stimulus and checked by a monitor on each
// handshake; per-cycle protocol checks are made inline.
// -----------------------------------------------------------------------------
module tb_core_ls_biu;
  import core_ls_biu_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_wen;
  logic [3:0]  req_wmask;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_wen;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;

  always #5 clk = ~clk;

  core_ls_biu #(.TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_wen       (req_wen),
    .req_wdata     (req_wdata),
    .req_wmask     (req_wmask),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .mem_rsp_err   (mem_rsp_err)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mreq_t;

  rsp_t  rsp_q[$];
  mreq_t mreq_q[$];
  rsp_t  mon_r;
  mreq_t mon_m;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard on both handshakes plus zero-payload checks.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) begin
        n_cmp++;
        if (mreq_q.size() == 0) begin
          n_bad++;
          $display("FAIL mem_req_unexpected: got addr 0x%08h, want no request", mem_addr);
        end else begin
          mon_m = mreq_q.pop_front();
          chk("mem_addr", mem_addr, mon_m.addr);
          chk("mem_wen", 32'(mem_wen), 32'(mon_m.wen));
          chk("mem_wdata", mem_wdata, mon_m.wdata);
          chk("mem_wmask", 32'(mem_wmask), 32'(mon_m.wmask));
        end
      end
      if (rsp_valid && rsp_ready) begin
        n_cmp++;
        if (rsp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rsp_unexpected: got rdata 0x%08h err %0d, want no response", rsp_rdata, rsp_err);
        end else begin
          mon_r = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, mon_r.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(mon_r.err));
        end
      end
      if (!mem_req_valid) chk("mem_payload_zero", 32'(|{mem_addr, mem_wen, mem_wdata, mem_wmask}), 32'd0);
      if (!rsp_valid) chk("rsp_payload_zero", 32'(|{rsp_rdata, rsp_err}), 32'd0);
    end
  end

  // One complete transaction. rsp_cyc is the WAIT_RSP cycle (1-based) in
  // which memory answers; 0 means never, so the timeout must fire.
  task automatic run_txn(
    input logic [31:0] addr, input logic [31:0] exp_maddr, input logic wen,
    input logic [31:0] wdata, input logic [3:0] wmask, input int mrdy_wait,
    input int rsp_cyc, input logic [31:0] bus_rdata, input logic bus_err,
    input int lsu_wait, input logic [31:0] exp_rdata, input logic exp_err
  );
    mreq_t m;
    rsp_t  r;
    int    n;
    m.addr = exp_maddr; m.wen = wen; m.wdata = wdata; m.wmask = wmask;
    mreq_q.push_back(m);
    r.rdata = exp_rdata; r.err = exp_err;
    rsp_q.push_back(r);

    req_valid = 1'b1; req_addr = addr; req_wen = wen; req_wdata = wdata; req_wmask = wmask;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    step();
    // Scramble the request bus: the BIU must be working from its own copy.
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wen = ~wen; req_wdata = ~wdata; req_wmask = ~wmask;

    for (int i = 0; i < mrdy_wait; i++) begin
      mem_rsp_valid = (i == 1); mem_rsp_rdata = 32'hBADB_AD00;
      @(negedge clk);
      chk("req_mem_valid", 32'(mem_req_valid), 32'd1);
      chk("req_addr_stable", mem_addr, exp_maddr);
      chk("req_wen_stable", 32'(mem_wen), 32'(wen));
      chk("req_wdata_stable", mem_wdata, wdata);
      chk("req_wmask_stable", 32'(mem_wmask), 32'(wmask));
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      step();
    end
    mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("req_mem_valid", 32'(mem_req_valid), 32'd1);
    step();
    mem_req_ready = 1'b0;

    n = (rsp_cyc == 0) ? TMO : rsp_cyc;
    for (int c = 1; c <= n; c++) begin
      mem_rsp_valid = (c == rsp_cyc); mem_rsp_rdata = bus_rdata; mem_rsp_err = bus_err;
      @(negedge clk);
      chk("wait_no_rsp", 32'(rsp_valid), 32'd0);
      chk("wait_no_mem_req", 32'(mem_req_valid), 32'd0);
      step();
    end
    mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0; mem_rsp_err = 1'b0;
    if (rsp_cyc == 0) begin
      // Late answer after the timeout: must not touch the error response.
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hFFFF_FFFF;
    end
    req_valid = 1'b1; req_addr = 32'h5A5A_5A5A;

    for (int i = 0; i < lsu_wait; i++) begin
      @(negedge clk);
      chk("rsp_valid_held", 32'(rsp_valid), 32'd1);
      chk("rsp_rdata_held", rsp_rdata, exp_rdata);
      chk("rsp_err_held", 32'(rsp_err), 32'(exp_err));
      chk("req_ready_in_rsp", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("req_ready_on_rsp_hs", 32'(req_ready), 32'd0);
    step();
    rsp_ready = 1'b0; req_valid = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0;
    @(negedge clk);
    chk("req_ready_after_rsp", 32'(req_ready), 32'd1);
    chk("no_accept_on_rsp_hs", 32'(mem_req_valid), 32'd0);
    chk("rsp_done", 32'(rsp_valid), 32'd0);
    step();
  endtask

  // Reset while the transaction sits in REQ (in_wait=0) or WAIT_RSP (in_wait=1).
  task automatic rst_mid(input int in_wait);
    mreq_t m;
    req_valid = 1'b1; req_addr = 32'h0000_0041; req_wen = 1'b0; req_wdata = 32'd0; req_wmask = 4'd0;
    step();
    req_valid = 1'b0;
    if (in_wait != 0) begin
      m.addr = 32'h0000_0040; m.wen = 1'b0; m.wdata = 32'd0; m.wmask = 4'd0;
      mreq_q.push_back(m);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      @(negedge clk);
      chk("pre_rst_wait", 32'(mem_req_valid), 32'd0);
    end else begin
      @(negedge clk);
      chk("pre_rst_req", 32'(mem_req_valid), 32'd1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      mem_rsp_valid = (i == 0); mem_rsp_rdata = 32'h1111_2222;
      @(negedge clk);
      chk("abandoned_no_rsp", 32'(rsp_valid), 32'd0);
      step();
    end
    mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0; rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_addr = 32'd0; req_wen = 1'b0; req_wdata = 32'd0; req_wmask = 4'd0;
    rsp_ready = 1'b0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0; mem_rsp_err = 1'b0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    step();

    // Zero-wait read: response 3 cycles after acceptance.
    run_txn(32'h8000_0006, 32'h8000_0004, 1'b0, 32'h0000_0000, 4'b0000,
            0, 1, 32'hDEAD_BEEF, 1'b0, 0, 32'hDEAD_BEEF, 1'b0);
    // Write with 4 cycles of memory backpressure: read data forced to zero.
    run_txn(32'h0000_1000, 32'h0000_1000, 1'b1, 32'h1234_5678, 4'b0011,
            4, 1, 32'hCAFE_F00D, 1'b0, 0, 32'h0000_0000, 1'b0);
    // Timeout: no response, error after 8 WAIT_RSP cycles, late answer ignored.
    run_txn(32'h0000_0004, 32'h0000_0004, 1'b0, 32'h0000_0000, 4'b0000,
            0, 0, 32'h0000_0000, 1'b0, 2, 32'h0000_0000, 1'b1);
    // Response exactly on the expiry cycle wins.
    run_txn(32'h0000_0008, 32'h0000_0008, 1'b0, 32'h0000_0000, 4'b0000,
            0, TMO, 32'h0BAD_CAFE, 1'b0, 0, 32'h0BAD_CAFE, 1'b0);
    // LSU backpressure for 5 cycles, memory error passed through.
    run_txn(32'h2000_0003, 32'h2000_0000, 1'b0, 32'h0000_0000, 4'b0000,
            1, 2, 32'h5555_AAAA, 1'b1, 5, 32'h5555_AAAA, 1'b1);

    rst_mid(0);
    rst_mid(1);

    // Normal operation after the abandoned transactions.
    run_txn(32'h0000_0010, 32'h0000_0010, 1'b0, 32'h0000_0000, 4'b0000,
            0, 3, 32'h0123_4567, 1'b0, 1, 32'h0123_4567, 1'b0);

    step();
    step();
    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    chk("mem_queue_drained", 32'(mreq_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
